serial_sub: RTL and testbench

Bit-serial WIDTH-bit subtractor computing q = a − b (mod 2^WIDTH) with borrow out, one bit per clock, under a start/busy/done handshake. It is the inverse-direction companion of the combinational 4-bit adder. Its results can be fed back through the adder (q + b == a) for round-trip checking. It sits beside the adder in the chapter 1 datapath and is driven by a stepped stimulus bench in the same style.

---
 rtl/serial_sub_if.sv | 18 +
 rtl/serial_sub.sv | 68 ++++++
 tb/tb_serial_sub.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serial_sub_if.sv
// serial_sub_if: start/busy/done handshake and operand/result bus for serial_sub; ovf exists only with SERIAL_SUB_OVF_EN
interface serial_sub_if #(parameter int WIDTH = 4);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] q;
   logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
   modport master (output start, a, b, input busy, done, q, borrow, ovf);
   modport slave  (input start, a, b, output busy, done, q, borrow, ovf);
`else
   modport master (output start, a, b, input busy, done, q, borrow);
   modport slave  (input start, a, b, output busy, done, q, borrow);
`endif
endinterface

// File: rtl/serial_sub.sv
// serial_sub: bit-serial a - b mod 2^WIDTH with borrow, LSB first; SERIAL_SUB_OVF_EN adds signed overflow output ovf
module serial_sub #(
   parameter int WIDTH = 4
) (
   input logic         ck,
   input logic         res,
   serial_sub_if.slave s
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] ra, rb, rq, q_r, rq_n;
   logic [CW-1:0]    cnt;
   logic             br, br_n, borrow_r, d, last;
   assign d      = ra[0] ^ rb[0] ^ br;
   assign br_n   = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
   assign rq_n   = {d, rq[WIDTH-1:1]};
   assign last   = cnt == CW'(WIDTH - 1);
   assign s.busy = state != IDLE;
   assign s.done = state == DONE;
   assign s.q    = q_r;
   assign s.borrow = borrow_r;
   // state register
   always_ff @(posedge ck or posedge res)
      if (res) state <= IDLE;
      else     state <= state_n;
   // next state: IDLE -> RUN on start, RUN -> DONE after the MSB, DONE -> IDLE
   always_comb begin
      state_n = state;
      if (state == IDLE && s.start) state_n = RUN;
      else if (state == RUN && last) state_n = DONE;
      else if (state == DONE) state_n = IDLE;
   end
   // operand capture, per-bit subtract/shift, and result load on the last bit
   always_ff @(posedge ck or posedge res)
      if (res) begin
         ra       <= '0;
         rb       <= '0;
         rq       <= '0;
         cnt      <= '0;
         br       <= 1'b0;
         q_r      <= '0;
         borrow_r <= 1'b0;
      end else if (state == IDLE && s.start) begin
         ra  <= s.a;
         rb  <= s.b;
         cnt <= '0;
         br  <= 1'b0;
      end else if (state == RUN) begin
         ra  <= ra >> 1;
         rb  <= rb >> 1;
         rq  <= rq_n;
         br  <= br_n;
         cnt <= last ? cnt : cnt + CW'(1);
         if (last) begin
            q_r      <= rq_n;
            borrow_r <= br_n;
         end
      end
`ifdef SERIAL_SUB_OVF_EN
   logic ovf_r;
   assign s.ovf = ovf_r;
   // on the last bit ra[0]/rb[0] hold the operand sign bits and d is the result sign bit
   always_ff @(posedge ck or posedge res)
      if (res) ovf_r <= 1'b0;
      else if (state == RUN && last) ovf_r <= (ra[0] != rb[0]) && (d != ra[0]);
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and randomized checks of serial_sub against an arithmetic model
module tb_serial_sub;
   localparam int W = 4;
   logic ck = 1'b0;
   logic res = 1'b1;
   int   passed = 0;
   int   total = 0;
   serial_sub_if #(.WIDTH(W)) s ();
   serial_sub #(.WIDTH(W)) dut (.ck(ck), .res(res), .s(s));
   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic run_op(input int av, input int bv, input int inj);
      int eq, eb, sa, sb, sd, eo;
      eq = (av + 16 - bv) % 16;
      eb = (av < bv) ? 1 : 0;
      sa = (av >= 8) ? av - 16 : av;
      sb = (bv >= 8) ? bv - 16 : bv;
      sd = sa - sb;
      eo = (sd < -8 || sd > 7) ? 1 : 0;
      @(negedge ck);
      s.a = 4'(av);
      s.b = 4'(bv);
      s.start = 1'b1;
      @(posedge ck);
      #1;
      s.start = 1'b0;
      s.a = 4'($urandom);
      s.b = 4'($urandom);
      chk("busy_after_accept", 16'(s.busy), 16'd1);
      chk("done_after_accept", 16'(s.done), 16'd0);
      for (int c = 1; c < W; c++) begin
         @(posedge ck);
         #1;
         s.start = (c == inj);
         if (c == inj) begin
            s.a = 4'd1;
            s.b = 4'd1;
         end
         chk("done_early", 16'(s.done), 16'd0);
         chk("busy_run", 16'(s.busy), 16'd1);
      end
      @(posedge ck);
      #1;
      s.start = 1'b0;
      chk("done_pulse", 16'(s.done), 16'd1);
      chk("q", 16'(s.q), 16'(eq));
      chk("borrow", 16'(s.borrow), 16'(eb));
      chk("adder_roundtrip", 16'((int'(s.q) + bv) % 16), 16'(av));
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf", 16'(s.ovf), 16'(eo));
`endif
      @(posedge ck);
      #1;
      chk("done_one_cycle", 16'(s.done), 16'd0);
      chk("busy_drop", 16'(s.busy), 16'd0);
      chk("q_held", 16'(s.q), 16'(eq));
   endtask

   initial begin
      s.start = 1'b0;
      s.a = '0;
      s.b = '0;
      #12;
      chk("rst_q", 16'(s.q), 16'd0);
      chk("rst_borrow", 16'(s.borrow), 16'd0);
      chk("rst_busy", 16'(s.busy), 16'd0);
      chk("rst_done", 16'(s.done), 16'd0);
`ifdef SERIAL_SUB_OVF_EN
      chk("rst_ovf", 16'(s.ovf), 16'd0);
`endif
      @(negedge ck);
      res = 1'b0;
      run_op(0, 0, -1);
      run_op(5, 5, -1);
      run_op(15, 1, -1);
      run_op(7, 15, -1);
      run_op(8, 1, -1);
      run_op(3, 1, -1);
      run_op(9, 3, 2);
      for (int i = 0; i < W + 2; i++) begin
         @(posedge ck);
         #1;
         chk("no_second_done", 16'(s.done), 16'd0);
         chk("no_second_busy", 16'(s.busy), 16'd0);
      end
      @(negedge ck);
      s.a = 4'hf;
      s.b = 4'h5;
      s.start = 1'b1;
      @(posedge ck);
      #1;
      s.start = 1'b0;
      @(posedge ck);
      #1;
      @(posedge ck);
      #1;
      res = 1'b1;
      #1;
      chk("abort_busy", 16'(s.busy), 16'd0);
      chk("abort_done", 16'(s.done), 16'd0);
      chk("abort_q", 16'(s.q), 16'd0);
      chk("abort_borrow", 16'(s.borrow), 16'd0);
      @(negedge ck);
      res = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         @(posedge ck);
         #1;
         chk("abort_no_done", 16'(s.done), 16'd0);
      end
      run_op(2, 3, -1);
      for (int i = 0; i < 20; i++) run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), -1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
